// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds and a CONFIG/RUN/ERROR mode machine.
// Latency: write visible in count next cycle; read data registered, valid one cycle after the pop edge.
// Backpressure: none; push while full or pop while empty is an error that parks the block in ERROR until init.
module fifo_umbral #(
  parameter int DATA_W       = 6,
  parameter int ADDR_W       = 3,
  parameter int UMB_ALTO_RST = 6,
  parameter int UMB_BAJO_RST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error_out,
  output logic [ADDR_W:0]   count
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_CONFIG = 2'b00,
    S_RUN    = 2'b01,
    S_ERROR  = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     alto_q, bajo_q;
  logic                umb_ok;
  logic                wr_en, rd_en, flush, ld_umb, err_set, err_clr;

  // Status flags are pure decodes of the registered occupancy and active thresholds.
  assign count        = count_q;
  assign fifo_full    = (count_q == DEPTH_C);
  assign fifo_empty   = (count_q == '0);
  assign almost_full  = (count_q >= alto_q);
  assign almost_empty = (count_q <= bajo_q);

  // A threshold pair is only accepted if it is ordered and fits the depth.
  assign umb_ok = (umbral_bajo < umbral_alto) && (umbral_alto <= DEPTH_C);

  // Mode machine: decides next state and which datapath actions happen this cycle.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    ld_umb  = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      S_CONFIG: begin
        if (init) begin
          ld_umb  = umb_ok;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // When full, a simultaneous pop frees a slot so the push is still taken.
        wr_en = push && (!fifo_full || pop);
        // No bypass: a pop on empty fails even if a push lands in the same cycle.
        rd_en = pop && !fifo_empty;
        if ((push && fifo_full && !pop) || (pop && fifo_empty)) begin
          err_set = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_ERROR: begin
        if (init) begin
          ld_umb  = umb_ok;
          flush   = 1'b1;
          err_clr = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_CONFIG;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_CONFIG;
    else       state_q <= state_d;
  end

  // Active thresholds, replaced only by a valid pair during init.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alto_q <= (ADDR_W+1)'(UMB_ALTO_RST);
      bajo_q <= (ADDR_W+1)'(UMB_BAJO_RST);
    end else if (ld_umb) begin
      alto_q <= umbral_alto;
      bajo_q <= umbral_bajo;
    end
  end

  // Pointers and occupancy; flush on error recovery, otherwise track accepted pushes/pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered read port; data_out holds its last value between successful pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_en;
      if (rd_en) data_out <= mem[rd_ptr];
    end
  end

  // Sticky error flag, set on overflow/underflow and cleared only by init recovery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        error_out <= 1'b0;
    else if (err_set) error_out <= 1'b1;
    else if (err_clr) error_out <= 1'b0;
  end

  // Storage array; no reset, contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_in;
  end

endmodule
